serial_add_sched: RTL and testbench

- Bit-serial N-bit adder built around one shared half_adder instance (ports inp1, inp2, out, carry).
- Each operand bit needs two half-adder evaluations. The first adds a_i and b_i. The second adds that partial sum and the running carry.
- This block schedules both passes on the single half_adder, holds the partial results and the running carry, and exposes a start/busy/done handshake.
- It replaces a ripple chain of full adders when area matters more than latency.

---
 rtl/serial_add_sched_pkg.sv | 18 +
 rtl/serial_add_sched_if.sv | 24 ++
 rtl/half_adder.sv | 10 +
 rtl/serial_add_sched.sv | 116 +++++++++++
 tb/tb_serial_add_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sched_pkg.sv
// Shared constants and state type for the bit-serial adder scheduler.
package serial_add_sched_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS1 = 2'd1;
    localparam logic [1:0] ST_PASS2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StPass1 = ST_PASS1,
        StPass2 = ST_PASS2,
        StDone  = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_add_sched_if.sv
// Start/busy/done handshake plus operand and result buses of the serial adder.
interface serial_add_sched_if
    import serial_add_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             carry;

    modport master (
        output start, inp1, inp2,
        input  busy, done, out, carry
    );

    modport slave (
        input  start, inp1, inp2,
        output busy, done, out, carry
    );
endinterface

// File: rtl/half_adder.sv
// Single-bit half adder shared by both passes of the serial adder.
module half_adder (
    input  logic inp1,
    input  logic inp2,
    output logic out,
    output logic carry
);
    assign out   = inp1 ^ inp2;
    assign carry = inp1 & inp2;
endmodule

// File: rtl/serial_add_sched.sv
// Bit-serial WIDTH-bit adder: two half-adder passes per bit on one shared half_adder.
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_add_sched_if.slave bus
);
    localparam int unsigned     IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              cin_q, cin_d;
    logic              s1_q, s1_d;
    logic              c1_q, c1_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              carry_q, carry_d;

    logic ha_a, ha_b, ha_sum, ha_co;

    half_adder u_ha (
        .inp1  (ha_a),
        .inp2  (ha_b),
        .out   (ha_sum),
        .carry (ha_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cin_d   = cin_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        carry_d = carry_q;
        ha_a    = 1'b0;
        ha_b    = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    a_d     = bus.inp1;
                    b_d     = bus.inp2;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    res_d   = '0;
                    state_d = StPass1;
                end
            end
            StPass1: begin
                ha_a    = a_q[idx_q];
                ha_b    = b_q[idx_q];
                s1_d    = ha_sum;
                c1_d    = ha_co;
                state_d = StPass2;
            end
            StPass2: begin
                ha_a         = s1_q;
                ha_b         = cin_q;
                res_d[idx_q] = ha_sum;
                // At most one of the two pass carries can be set, so OR is the full carry.
                cin_d        = c1_q | ha_co;
                if (idx_q == LastIdx) begin
                    out_d   = res_d;
                    carry_d = cin_d;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StPass1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cin_q   <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cin_q   <= cin_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign bus.busy  = (state_q == StPass1) || (state_q == StPass2);
    assign bus.done  = (state_q == StDone);
    assign bus.out   = out_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched: cycle-level latency/result model plus literal checks.
module tb_serial_add_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_sched_if #(.WIDTH(8)) bus8 ();
    serial_add_sched_if #(.WIDTH(1)) bus1 ();

    serial_add_sched #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_add_sched #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted op keeps busy for 2*WIDTH cycles, then one done cycle with A+B.
    int         m_cnt;
    logic       m_done;
    logic [7:0] m_out;
    logic       m_carry;
    logic [8:0] m_pend;
    bit         model_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_done = 1'b0; m_out = '0; m_carry = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_cnt == 0) {m_carry, m_out} = m_pend;
        end else begin
            m_done = 1'b0;
            if (bus8.start) begin
                m_pend = {1'b0, bus8.inp1} + {1'b0, bus8.inp2};
                m_cnt  = 16;
            end
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("model_busy",  32'(bus8.busy),  32'(m_cnt > 0));
            check("model_done",  32'(bus8.done),  32'(m_done));
            check("model_out",   32'(bus8.out),   32'(m_out));
            check("model_carry", 32'(bus8.carry), 32'(m_carry));
        end
    end

    task automatic accept8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.start = 1'b1; bus8.inp1 = a; bus8.inp2 = b;
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    // Called #1 after the accepting edge; n = edges until done, nb = busy samples.
    task automatic wait_done8(output int n, output int nb);
        n  = 0;
        nb = int'(bus8.busy);
        while (!bus8.done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus8.busy) nb++;
        end
        check("done8_seen", 32'(bus8.done), 32'd1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic ec);
        int n, nb;
        accept8(a, b);
        wait_done8(n, nb);
        check("latency8", 32'(n), 32'd16);
        check("busy_len8", 32'(nb), 32'd16);
        check("out8", 32'(bus8.out), 32'(eo));
        check("carry8", 32'(bus8.carry), 32'(ec));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n, nb, dn, t1, t2;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.inp1 = '0; bus8.inp2 = '0;
        bus1.start = 1'b0; bus1.inp1 = '0; bus1.inp2 = '0;
        repeat (2) @(posedge clk);
        #1 model_en = 1'b1;
        check("rst_busy8", 32'(bus8.busy), 32'd0);
        check("rst_done8", 32'(bus8.done), 32'd0);
        check("rst_out8", 32'(bus8.out), 32'd0);
        check("rst_carry8", 32'(bus8.carry), 32'd0);
        check("rst_busy1", 32'(bus1.busy), 32'd0);
        @(negedge clk) rst = 1'b0;

        run8(8'h00, 8'h00, 8'h00, 1'b0);
        run8(8'hFF, 8'h01, 8'h00, 1'b1);
        run8(8'hA5, 8'h5A, 8'hFF, 1'b0);
        run8(8'h80, 8'h80, 8'h00, 1'b1);

        // start while busy must be ignored
        accept8(8'h03, 8'h04);
        repeat (4) @(posedge clk);
        #1 accept8(8'h01, 8'h01);
        wait_done8(n, nb);
        check("ignored_out", 32'(bus8.out), 32'h07);
        check("ignored_carry", 32'(bus8.carry), 32'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus8.done) dn++;
        end
        check("no_second_done", 32'(dn), 32'd0);

        // mid-operation reset
        accept8(8'h3C, 8'h0F);
        repeat (6) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_busy", 32'(bus8.busy), 32'd0);
        check("midrst_done", 32'(bus8.done), 32'd0);
        check("midrst_out", 32'(bus8.out), 32'd0);
        check("midrst_carry", 32'(bus8.carry), 32'd0);
        run8(8'h10, 8'h20, 8'h30, 1'b0);

        // back-to-back: start held, new operands presented in the done cycle
        @(negedge clk);
        bus8.start = 1'b1; bus8.inp1 = 8'h7F; bus8.inp2 = 8'h01;
        @(posedge clk); #1;
        wait_done8(n, nb);
        check("b2b_lat1", 32'(n), 32'd16);
        t1 = cyc;
        check("b2b_out1", 32'(bus8.out), 32'h80);
        check("b2b_carry1", 32'(bus8.carry), 32'd0);
        bus8.inp1 = 8'hF0; bus8.inp2 = 8'h20;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        check("b2b_busy_after_done", 32'(bus8.busy), 32'd1);
        check("b2b_out_held", 32'(bus8.out), 32'h80);
        wait_done8(n, nb);
        t2 = cyc;
        check("b2b_spacing", 32'(t2 - t1), 32'd17);
        check("b2b_out2", 32'(bus8.out), 32'h10);
        check("b2b_carry2", 32'(bus8.carry), 32'd1);

        // WIDTH=1 instance: 1+0 first, then 1+1 with out held during busy
        @(negedge clk);
        bus1.start = 1'b1; bus1.inp1 = 1'b1; bus1.inp2 = 1'b0;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("w1_lat_a", 32'(n), 32'd2);
        check("w1_out_a", 32'(bus1.out), 32'd1);
        check("w1_carry_a", 32'(bus1.carry), 32'd0);

        @(negedge clk);
        bus1.start = 1'b1; bus1.inp1 = 1'b1; bus1.inp2 = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        n = 0;
        while (!bus1.done && n < 20) begin
            check("w1_busy", 32'(bus1.busy), 32'd1);
            check("w1_out_stable", 32'(bus1.out), 32'd1);
            check("w1_carry_stable", 32'(bus1.carry), 32'd0);
            @(posedge clk); #1; n++;
        end
        check("w1_lat_b", 32'(n), 32'd2);
        check("w1_out_b", 32'(bus1.out), 32'd0);
        check("w1_carry_b", 32'(bus1.carry), 32'd1);
        @(posedge clk); #1;
        check("w1_idle_after", 32'({bus1.busy, bus1.done}), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
